// File: rtl/rrat_commit.sv
// ---------------------------------------------------------------------------
// rrat_commit
//   Retirement register alias table plus physical-register reclaim FIFO.
//   Sits directly behind the ROB commit port. Every accepted commit group
//   updates the committed arch->phys map. Each displaced physical register
//   is queued in a small free FIFO, and the FIFO drains into the rename
//   free list.
//
//   Handshake: the ROB pops a group only when i_commit_valid is high and
//   o_commit_stall is low (accept). On the drain side, all asserted
//   o_free_valid slots are consumed on any cycle with i_free_ready high.
//   o_commit_stall is a pure function of the registered FIFO count.
//
//   Optional feature macro: RRAT_RETIRE_CNT_EN adds o_retire_count.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_commit_valid      ROB presents a commit group
//   i_commit_slot_en    per-slot real instruction
//   i_commit_rd_arch    per-slot architectural destination
//   i_commit_rd_phys    per-slot physical destination from rename
//   i_commit_rd_we      per-slot writes a register
//   o_commit_stall      ROB must not pop this cycle
//   o_free_valid        per-slot reclaimed register valid (slot 0 oldest)
//   o_free_preg         per-slot reclaimed physical register
//   i_free_ready        free list takes every valid slot this cycle
//   o_rrat_map          committed mapping, used for flush recovery
//   o_retire_count      retired instruction count (RRAT_RETIRE_CNT_EN only)
// ---------------------------------------------------------------------------
module rrat_commit #(
  parameter int SS         = 2,
  parameter int N_ARCH     = 32,
  parameter int N_PHYS     = 64,
  parameter int FREE_DEPTH = 8,
  localparam int PW        = $clog2(N_PHYS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_commit_valid,
  input  logic [SS-1:0]                i_commit_slot_en,
  input  logic [SS-1:0][4:0]           i_commit_rd_arch,
  input  logic [SS-1:0][PW-1:0]        i_commit_rd_phys,
  input  logic [SS-1:0]                i_commit_rd_we,
  output logic                         o_commit_stall,
  output logic [SS-1:0]                o_free_valid,
  output logic [SS-1:0][PW-1:0]        o_free_preg,
  input  logic                         i_free_ready,
  output logic [N_ARCH-1:0][PW-1:0]    o_rrat_map
`ifdef RRAT_RETIRE_CNT_EN
  ,
  output logic [63:0]                  o_retire_count
`endif
);

  localparam int AW = $clog2(FREE_DEPTH);
  localparam int CW = AW + 1;
  // A full group of SS pushes must always fit, so stall once fewer than SS
  // entries remain free.
  localparam logic [CW-1:0] STALL_TH = CW'(FREE_DEPTH - SS);

  logic [N_ARCH-1:0][PW-1:0] r_map;
  logic [PW-1:0]             r_fifo [FREE_DEPTH];
  logic [AW-1:0]             r_head;
  logic [AW-1:0]             r_tail;
  logic [CW-1:0]             r_count;

  logic                      w_accept;
  logic [SS-1:0]             w_eff;
  logic [N_ARCH-1:0][PW-1:0] w_map_next;
  logic [SS-1:0][PW-1:0]     w_old;
  logic [SS-1:0][AW-1:0]     w_off;
  logic [CW-1:0]             w_push_cnt;
  logic [CW-1:0]             w_pop_cnt;

  assign o_commit_stall = (r_count > STALL_TH);
  assign w_accept       = i_commit_valid & ~o_commit_stall;

  // Effective write: retiring slot that writes a register other than x0.
  always_comb begin
    for (int i = 0; i < SS; i++) begin
      w_eff[i] = w_accept & i_commit_slot_en[i] & i_commit_rd_we[i] &
                 (i_commit_rd_arch[i] != 5'd0);
    end
  end

  // Apply slots in order so each slot sees the mapping left by older slots
  // of the same group; w_off compacts the pushes onto consecutive entries.
  always_comb begin
    logic [AW-1:0] v_acc;
    w_map_next = r_map;
    v_acc      = '0;
    for (int i = 0; i < SS; i++) begin
      w_old[i] = w_map_next[i_commit_rd_arch[i]];
      w_off[i] = v_acc;
      if (w_eff[i]) begin
        w_map_next[i_commit_rd_arch[i]] = i_commit_rd_phys[i];
        v_acc = v_acc + AW'(1);
      end
    end
    w_push_cnt = {1'b0, v_acc};
  end

  // Drain side: the head SS entries are shown, all of them popped on ready.
  always_comb begin
    w_pop_cnt = '0;
    for (int i = 0; i < SS; i++) begin
      o_free_valid[i] = (r_count > CW'(i));
      o_free_preg[i]  = r_fifo[r_head + AW'(i)];
      if (i_free_ready && o_free_valid[i]) begin
        w_pop_cnt = w_pop_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ARCH; i++) begin
        r_map[i] <= PW'(i);
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_map   <= w_map_next;
      r_head  <= r_head + w_pop_cnt[AW-1:0];
      r_tail  <= r_tail + w_push_cnt[AW-1:0];
      r_count <= r_count + w_push_cnt - w_pop_cnt;
    end
  end

  // Entry storage needs no reset: the count gates what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SS; i++) begin
      if (w_eff[i]) begin
        r_fifo[r_tail + w_off[i]] <= w_old[i];
      end
    end
  end

  assign o_rrat_map = r_map;

`ifdef RRAT_RETIRE_CNT_EN
  logic [63:0] r_retire_count;
  logic [63:0] w_ret_inc;

  // Counts every retiring slot, writing or not.
  always_comb begin
    w_ret_inc = '0;
    for (int i = 0; i < SS; i++) begin
      if (w_accept && i_commit_slot_en[i]) begin
        w_ret_inc = w_ret_inc + 64'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_count <= '0;
    end else begin
      r_retire_count <= r_retire_count + w_ret_inc;
    end
  end

  assign o_retire_count = r_retire_count;
`endif

endmodule

// File: tb/tb_rrat_commit.sv
// ---------------------------------------------------------------------------
// tb_rrat_commit
//   Self-checking bench for rrat_commit. A bench-side map model and an
//   expected free queue (exp_q) are updated when each cycle's stimulus is
//   driven. Outputs are compared one cycle later, at posedge + 1.
// ---------------------------------------------------------------------------
module tb_rrat_commit;
  localparam int SS         = 2;
  localparam int N_ARCH     = 32;
  localparam int N_PHYS     = 64;
  localparam int FREE_DEPTH = 8;
  localparam int PW         = 6;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                      i_commit_valid;
  logic [SS-1:0]             i_commit_slot_en;
  logic [SS-1:0][4:0]        i_commit_rd_arch;
  logic [SS-1:0][PW-1:0]     i_commit_rd_phys;
  logic [SS-1:0]             i_commit_rd_we;
  logic                      o_commit_stall;
  logic [SS-1:0]             o_free_valid;
  logic [SS-1:0][PW-1:0]     o_free_preg;
  logic                      i_free_ready;
  logic [N_ARCH-1:0][PW-1:0] o_rrat_map;
`ifdef RRAT_RETIRE_CNT_EN
  logic [63:0]               o_retire_count;
`endif

  rrat_commit #(
    .SS(SS), .N_ARCH(N_ARCH), .N_PHYS(N_PHYS), .FREE_DEPTH(FREE_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_commit_valid   (i_commit_valid),
    .i_commit_slot_en (i_commit_slot_en),
    .i_commit_rd_arch (i_commit_rd_arch),
    .i_commit_rd_phys (i_commit_rd_phys),
    .i_commit_rd_we   (i_commit_rd_we),
    .o_commit_stall   (o_commit_stall),
    .o_free_valid     (o_free_valid),
    .o_free_preg      (o_free_preg),
    .i_free_ready     (i_free_ready),
    .o_rrat_map       (o_rrat_map)
`ifdef RRAT_RETIRE_CNT_EN
    ,
    .o_retire_count   (o_retire_count)
`endif
  );

  // scoreboard / model state
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] m_map [N_ARCH];
  logic [63:0]   m_ret;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int a = 0; a < N_ARCH; a++) m_map[a] = PW'(a);
    m_ret = '0;
  endtask

  // Compare every registered output against the model.
  task automatic check_outputs();
    int sz;
    logic [SS-1:0] ev;
    sz = exp_q.size();
    ev = (sz >= 2) ? 2'b11 : ((sz == 1) ? 2'b01 : 2'b00);
    check("free_valid", 64'(o_free_valid), 64'(ev));
    for (int i = 0; i < SS; i++) begin
      if (i < sz) check($sformatf("free_preg[%0d]", i), 64'(o_free_preg[i]), 64'(exp_q[i]));
    end
    check("commit_stall", 64'(o_commit_stall), 64'(sz > FREE_DEPTH - SS));
    for (int a = 0; a < N_ARCH; a++) begin
      check($sformatf("rrat_map[%0d]", a), 64'(o_rrat_map[a]), 64'(m_map[a]));
    end
`ifdef RRAT_RETIRE_CNT_EN
    check("retire_count", o_retire_count, m_ret);
`endif
  endtask

  // driver: one clock cycle of stimulus plus the matching model update
  task automatic drive_cycle(input logic v, input logic [1:0] en, input logic [1:0] we,
                             input logic [4:0] a0, input logic [4:0] a1,
                             input logic [5:0] p0, input logic [5:0] p1,
                             input logic rdy);
    logic [4:0] ar [2];
    logic [5:0] ph [2];
    logic       stall_exp;
    int         pops;
    check_outputs();
    i_commit_valid      = v;
    i_commit_slot_en    = en;
    i_commit_rd_we      = we;
    i_commit_rd_arch[0] = a0;
    i_commit_rd_arch[1] = a1;
    i_commit_rd_phys[0] = p0;
    i_commit_rd_phys[1] = p1;
    i_free_ready        = rdy;
    ar[0] = a0; ar[1] = a1; ph[0] = p0; ph[1] = p1;
    stall_exp = (exp_q.size() > FREE_DEPTH - SS);
    pops = rdy ? ((exp_q.size() >= SS) ? SS : exp_q.size()) : 0;
    for (int k = 0; k < pops; k++) void'(exp_q.pop_front());
    if (v && !stall_exp) begin
      for (int i = 0; i < SS; i++) begin
        if (en[i]) begin
          m_ret = m_ret + 64'd1;
          if (we[i] && ar[i] != 5'd0) begin
            exp_q.push_back(m_map[ar[i]]);
            m_map[ar[i]] = ph[i];
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, rdy);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    i_commit_valid   = 1'b0;
    i_commit_slot_en = '0;
    i_commit_rd_we   = '0;
    i_commit_rd_arch = '0;
    i_commit_rd_phys = '0;
    i_free_ready     = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();
    do_reset();

    // reset then idle
    check("reset_map5", 64'(o_rrat_map[5]), 64'd5);
    check("reset_free_valid", 64'(o_free_valid), 64'd0);
    check("reset_stall", 64'(o_commit_stall), 64'd0);
    idle(1'b0, 2);

    // single commit x5 -> p40
    drive_cycle(1'b1, 2'b01, 2'b01, 5'd5, 5'd0, 6'd40, 6'd0, 1'b0);
    check("single_map5", 64'(o_rrat_map[5]), 64'd40);
    check("single_free_valid", 64'(o_free_valid), 64'd1);
    check("single_free_preg0", 64'(o_free_preg[0]), 64'd5);
    idle(1'b1, 1);
    check("single_drained", 64'(o_free_valid), 64'd0);

    // same-rd pair: younger wins, older phys freed second
    drive_cycle(1'b1, 2'b11, 2'b11, 5'd7, 5'd7, 6'd41, 6'd42, 1'b0);
    check("pair_map7", 64'(o_rrat_map[7]), 64'd42);
    check("pair_free_preg0", 64'(o_free_preg[0]), 64'd7);
    check("pair_free_preg1", 64'(o_free_preg[1]), 64'd41);
    idle(1'b1, 2);

    // x0 destination and non-writing slot: no map or FIFO effect
    drive_cycle(1'b1, 2'b11, 2'b01, 5'd0, 5'd3, 6'd50, 6'd51, 1'b0);
    check("x0_map0", 64'(o_rrat_map[0]), 64'd0);
    check("x0_map3", 64'(o_rrat_map[3]), 64'd3);
    check("x0_free_valid", 64'(o_free_valid), 64'd0);
`ifdef RRAT_RETIRE_CNT_EN
    check("x0_retire_count", o_retire_count, 64'd5);
`endif

    // back-pressure: fill the FIFO with the free list stalled
    drive_cycle(1'b1, 2'b11, 2'b11, 5'd10, 5'd11, 6'd44, 6'd45, 1'b0);
    drive_cycle(1'b1, 2'b11, 2'b11, 5'd12, 5'd13, 6'd46, 6'd47, 1'b0);
    drive_cycle(1'b1, 2'b11, 2'b11, 5'd14, 5'd15, 6'd48, 6'd49, 1'b0);
    check("bp_six_no_stall", 64'(o_commit_stall), 64'd0);
    drive_cycle(1'b1, 2'b11, 2'b11, 5'd16, 5'd17, 6'd52, 6'd53, 1'b0);
    check("bp_stall_set", 64'(o_commit_stall), 64'd1);
    // commit_valid while stalled must be ignored
    drive_cycle(1'b1, 2'b11, 2'b11, 5'd20, 5'd21, 6'd54, 6'd55, 1'b0);
    check("bp_ignored_map20", 64'(o_rrat_map[20]), 64'd20);
    drive_cycle(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 1'b1);
    check("bp_stall_clr", 64'(o_commit_stall), 64'd0);
    idle(1'b1, 4);

    // random traffic with toggling drain, wrapping the pointers
    for (int k = 0; k < 30; k++) begin
      drive_cycle(1'b1, 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)),
                  6'(32 + ((2 * k) % 32)), 6'(33 + ((2 * k) % 32)),
                  1'(k % 2));
    end
    idle(1'b1, 6);

    // reset with three queued entries
    drive_cycle(1'b1, 2'b11, 2'b11, 5'd3, 5'd4, 6'd56, 6'd57, 1'b0);
    drive_cycle(1'b1, 2'b01, 2'b01, 5'd6, 5'd0, 6'd58, 6'd0, 1'b0);
    check("pre_rst_free_valid", 64'(o_free_valid), 64'd3);
    do_reset();
    check("rst_free_valid", 64'(o_free_valid), 64'd0);
    check("rst_map3", 64'(o_rrat_map[3]), 64'd3);
    check("rst_stall", 64'(o_commit_stall), 64'd0);
    idle(1'b1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
